crc_fcs_check: RTL and testbench

//  Receive-side FCS checker in the segmented CRC pipeline.

---
 rtl/crc_pipe_pkg.sv | 24 ++
 rtl/crc_fcs_fifo.sv | 52 +++++
 rtl/crc_fcs_check.sv | 211 +++++++++++++++++++++
 tb/tb_crc_fcs_check.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pipe_pkg.sv
// Shared definitions for the segmented CRC pipeline: framing FSM encoding,
// sticky error bit positions and the pending-FCS entry layout.
package crc_pipe_pkg;

  // Framing state of the receive word stream
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } fsm_state_t;

  // Bit positions inside err_sticky = {underflow, overflow, framing}
  localparam int ERR_FRAMING   = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_UNDERFLOW = 2;
  localparam int ERR_W         = 3;

  localparam int FCS_W = 32;

  // Width of one queued entry {fcs, len, runt}
  function automatic int fcs_entry_width(input int mod_width);
    return FCS_W + mod_width + 1;
  endfunction

endpackage

// File: rtl/crc_fcs_fifo.sv
// Synchronous FIFO holding extracted FCS entries until the CRC pipeline
// returns the matching computed CRC. The caller only issues legal requests:
// i_pop when not empty, i_push when not full or popping in the same cycle.
module crc_fcs_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Extra pointer bit distinguishes full from empty when the indices match
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  // Advance read/write pointers; push and pop may both happen in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/crc_fcs_check.sv
// Receive-side FCS checker. Pulls the trailing 4 FCS bytes out of each packet,
// queues them, and compares against the computed CRC when crc_en returns it.
// Optional feature macro: CRC_CHK_STATS_EN enables the good/bad packet counters;
// without it good_cnt/bad_cnt are tied to zero.
module crc_fcs_check
  import crc_pipe_pkg::*;
#(
  parameter int          MOD_WIDTH  = 12,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] CRC_XOROUT = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sop_in,
  input  logic                 eop_in,
  input  logic                 dval_in,
  input  logic [MOD_WIDTH-1:0] mod_in,
  input  logic [31:0]          din,
  input  logic                 crc_en,
  input  logic [31:0]          crc_in,
  output logic                 chk_valid,
  output logic                 chk_ok,
  output logic [MOD_WIDTH-1:0] chk_len,
  output logic [ERR_W-1:0]     err_sticky,
  output logic [31:0]          good_cnt,
  output logic [31:0]          bad_cnt
);

  localparam int ENTRY_W = fcs_entry_width(MOD_WIDTH);
  localparam logic [MOD_WIDTH-1:0] LEN_ONE = {{(MOD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MOD_WIDTH-1:0] LEN_MIN = {{(MOD_WIDTH-3){1'b0}}, 3'b100};

  fsm_state_t           r_state;
  logic [31:0]          r_prev;
  logic [ERR_W-1:0]     r_err;
  logic                 r_chk_valid;
  logic                 r_chk_ok;
  logic [MOD_WIDTH-1:0] r_chk_len;

  logic                 w_push_req;
  logic                 w_frame_err;
  logic                 w_push_ok;
  logic                 w_pop_ok;
  logic                 w_full;
  logic                 w_empty;
  logic [ERR_W-1:0]     w_err_set;
  logic [31:0]          w_prev_eff;
  logic [MOD_WIDTH-1:0] w_lenm1;
  logic [1:0]           w_shift_bytes;
  logic [63:0]          w_shifted;
  logic [31:0]          w_fcs;
  logic                 w_runt;
  logic [ENTRY_W-1:0]   w_push_entry;
  logic [ENTRY_W-1:0]   w_head;
  logic [31:0]          w_head_fcs;
  logic [MOD_WIDTH-1:0] w_head_len;
  logic                 w_head_runt;

  // FCS extraction: the last 4 bytes end at lane v-1 of the eop word,
  // so shift the {prev, din} window right by the unused trailing lanes.
  assign w_prev_eff    = (sop_in && eop_in) ? 32'h00000000 : r_prev;
  assign w_lenm1       = mod_in - LEN_ONE;
  assign w_shift_bytes = 2'd3 - w_lenm1[1:0];
  assign w_shifted     = {w_prev_eff, din} >> {w_shift_bytes, 3'b000};
  assign w_fcs         = w_shifted[31:0];
  assign w_runt        = (mod_in < LEN_MIN);
  assign w_push_entry  = {w_fcs, mod_in, w_runt};

  assign w_head_fcs  = w_head[ENTRY_W-1 -: 32];
  assign w_head_len  = w_head[MOD_WIDTH:1];
  assign w_head_runt = w_head[0];

  // Decide whether this word closes a packet and whether framing was violated
  always_comb begin
    w_push_req  = 1'b0;
    w_frame_err = 1'b0;
    if (dval_in) begin
      case (r_state)
        ST_IDLE: begin
          if (sop_in) begin
            w_push_req = eop_in;
          end else if (eop_in) begin
            w_frame_err = 1'b1;
          end else begin
            w_push_req = 1'b0;
          end
        end
        ST_IN_PKT: begin
          if (sop_in) begin
            w_frame_err = 1'b1;
            w_push_req  = eop_in;
          end else begin
            w_push_req  = eop_in;
          end
        end
        default: begin
          w_push_req  = 1'b0;
          w_frame_err = 1'b0;
        end
      endcase
    end else begin
      w_push_req  = 1'b0;
      w_frame_err = 1'b0;
    end
  end

  // Queue arbitration: a full queue still accepts a push when it pops that cycle
  always_comb begin
    w_pop_ok  = crc_en && !w_empty;
    w_push_ok = w_push_req && (!w_full || w_pop_ok);
    w_err_set = '0;
    w_err_set[ERR_FRAMING]   = w_frame_err;
    w_err_set[ERR_OVERFLOW]  = w_push_req && w_full && !w_pop_ok;
    w_err_set[ERR_UNDERFLOW] = crc_en && w_empty;
  end

  crc_fcs_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_ok),
    .i_data  (w_push_entry),
    .i_pop   (w_pop_ok),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Framing FSM and previous-word register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_prev  <= 32'h00000000;
    end else begin
      if (dval_in) begin
        r_prev <= din;
        case (r_state)
          ST_IDLE: begin
            if (sop_in && !eop_in) begin
              r_state <= ST_IN_PKT;
            end
          end
          ST_IN_PKT: begin
            if (eop_in) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      r_err <= r_err | w_err_set;
    end
  end

  // Registered compare result, one cycle after the popping crc_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_valid <= 1'b0;
      r_chk_ok    <= 1'b0;
      r_chk_len   <= '0;
    end else begin
      r_chk_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_chk_ok  <= !w_head_runt && (w_head_fcs == (crc_in ^ CRC_XOROUT));
        r_chk_len <= w_head_len;
      end
    end
  end

  assign chk_valid  = r_chk_valid;
  assign chk_ok     = r_chk_ok;
  assign chk_len    = r_chk_len;
  assign err_sticky = r_err;

`ifdef CRC_CHK_STATS_EN
  logic [31:0] r_good_cnt;
  logic [31:0] r_bad_cnt;

  // Saturating pass/fail counters driven from the registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_good_cnt <= 32'h00000000;
      r_bad_cnt  <= 32'h00000000;
    end else begin
      if (r_chk_valid && r_chk_ok && (r_good_cnt != 32'hFFFFFFFF)) begin
        r_good_cnt <= r_good_cnt + 32'h00000001;
      end
      if (r_chk_valid && !r_chk_ok && (r_bad_cnt != 32'hFFFFFFFF)) begin
        r_bad_cnt <= r_bad_cnt + 32'h00000001;
      end
    end
  end

  assign good_cnt = r_good_cnt;
  assign bad_cnt  = r_bad_cnt;
`else
  assign good_cnt = 32'h00000000;
  assign bad_cnt  = 32'h00000000;
`endif

endmodule

// File: tb/tb_crc_fcs_check.sv
// Scoreboard bench for crc_fcs_check: stimulus pushes expected {ok,len} per
// issued crc_en; a monitor pops and compares on every chk_valid.
module tb_crc_fcs_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sop_in = 1'b0;
  logic        eop_in = 1'b0;
  logic        dval_in = 1'b0;
  logic [11:0] mod_in = 12'h000;
  logic [31:0] din = 32'h0;
  logic        crc_en = 1'b0;
  logic [31:0] crc_in = 32'h0;
  logic        chk_valid;
  logic        chk_ok;
  logic [11:0] chk_len;
  logic [2:0]  err_sticky;
  logic [31:0] good_cnt;
  logic [31:0] bad_cnt;

  int total = 0;
  int bad = 0;
  logic [12:0] exp_q [$];
  logic [7:0]  pkt [$];

  crc_fcs_check dut (
    .clk(clk), .rst(rst), .sop_in(sop_in), .eop_in(eop_in), .dval_in(dval_in),
    .mod_in(mod_in), .din(din), .crc_en(crc_en), .crc_in(crc_in),
    .chk_valid(chk_valid), .chk_ok(chk_ok), .chk_len(chk_len),
    .err_sticky(err_sticky), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every result strobe must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && chk_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_chk_valid: got len %0d ok %0d want none", chk_len, chk_ok);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("chk_ok", {31'd0, chk_ok}, {31'd0, e[12]});
        check("chk_len", {20'd0, chk_len}, {20'd0, e[11:0]});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_pkt(input int n, input logic [7:0] base, input logic [31:0] fcs);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(base + 8'(i));
    pkt.push_back(fcs[31:24]);
    pkt.push_back(fcs[23:16]);
    pkt.push_back(fcs[15:8]);
    pkt.push_back(fcs[7:0]);
  endtask

  task automatic send_pkt(input int len, input bit crc_at_eop, input logic [31:0] crc,
                          input bit exp_ok, input int exp_len);
    int nw;
    logic [31:0] word;
    nw = (len + 3) / 4;
    if (nw == 0) nw = 1;
    for (int w = 0; w < nw; w++) begin
      word = 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b < pkt.size()) word[31 - 8 * b -: 8] = pkt[w * 4 + b];
      end
      dval_in = 1'b1;
      sop_in  = (w == 0);
      eop_in  = (w == nw - 1);
      din     = word;
      mod_in  = (w == nw - 1) ? 12'(len) : 12'h000;
      if ((w == nw - 1) && crc_at_eop) begin
        exp_q.push_back({exp_ok, 12'(exp_len)});
        crc_en = 1'b1;
        crc_in = crc;
      end
      tick();
    end
    dval_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0; mod_in = 12'h000; crc_en = 1'b0;
  endtask

  task automatic issue_crc(input logic [31:0] crc, input bit expect_res, input bit exp_ok,
                           input int exp_len);
    if (expect_res) exp_q.push_back({exp_ok, 12'(exp_len)});
    crc_en = 1'b1;
    crc_in = crc;
    tick();
    crc_en = 1'b0;
  endtask

  task automatic single(input logic [31:0] w);
    pkt.delete();
    pkt.push_back(w[31:24]); pkt.push_back(w[23:16]);
    pkt.push_back(w[15:8]);  pkt.push_back(w[7:0]);
    send_pkt(4, 1'b0, 32'h0, 1'b0, 0);
  endtask

  task automatic apply_reset;
    idle(3);
    check("pending_results", exp_q.size(), 0);
    rst = 1'b1;
    tick();
    check("rst_chk_valid", {31'd0, chk_valid}, 32'd0);
    check("rst_chk_ok", {31'd0, chk_ok}, 32'd0);
    check("rst_chk_len", {20'd0, chk_len}, 32'd0);
    check("rst_err", {29'd0, err_sticky}, 32'd0);
    check("rst_good", good_cnt, 32'd0);
    check("rst_bad", bad_cnt, 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [31:0] lane_fcs [4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hC0FFEE11};

  initial begin
    apply_reset();

    // Pass vector: "123456789" + CB F4 39 26, crc_en three cycles after eop
    load_pkt(9, 8'h31, 32'hCBF43926);
    send_pkt(13, 1'b0, 32'h0, 1'b0, 0);
    idle(2);
    issue_crc(32'hCBF43926, 1'b1, 1'b1, 13);
    idle(2);

    // Every eop lane position, good then one flipped FCS bit
    for (int k = 0; k < 4; k++) begin
      load_pkt(4 + k, 8'hA0, lane_fcs[k]);
      send_pkt(8 + k, 1'b0, 32'h0, 1'b0, 0);
      idle(2);
      issue_crc(lane_fcs[k], 1'b1, 1'b1, 8 + k);
      load_pkt(4 + k, 8'h50, lane_fcs[k] ^ (32'h00000100 << k));
      send_pkt(8 + k, 1'b0, 32'h0, 1'b0, 0);
      idle(2);
      issue_crc(lane_fcs[k], 1'b1, 1'b0, 8 + k);
    end

    // Runt fails even with the extracted value as crc_in
    pkt.delete();
    pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33);
    send_pkt(3, 1'b0, 32'h0, 1'b0, 0);
    idle(2);
    issue_crc(32'h00112233, 1'b1, 1'b0, 3);
    // Single-word packet
    single(32'h11223344);
    idle(2);
    issue_crc(32'h11223344, 1'b1, 1'b1, 4);
    idle(3);
    check("err_clean", {29'd0, err_sticky}, 32'd0);

    // Overflow: five eops into a four-deep queue
    for (int i = 0; i < 5; i++) begin
      single(32'h5A000000 + 32'(i));
      idle(1);
    end
    check("err_overflow", {29'd0, err_sticky}, 32'h2);
    for (int i = 0; i < 4; i++) issue_crc(32'h5A000000 + 32'(i), 1'b1, 1'b1, 4);
    issue_crc(32'h5A000004, 1'b0, 1'b0, 0);
    idle(2);
    check("err_underflow", {29'd0, err_sticky}, 32'h6);

    // Push and pop together while full
    apply_reset();
    for (int i = 0; i < 4; i++) single(32'h6B000000 + 32'(i));
    pkt.delete();
    pkt.push_back(8'h6B); pkt.push_back(8'h00); pkt.push_back(8'h00); pkt.push_back(8'h04);
    send_pkt(4, 1'b1, 32'h6B000000, 1'b1, 4);
    idle(1);
    for (int i = 1; i < 5; i++) issue_crc(32'h6B000000 + 32'(i), 1'b1, 1'b1, 4);
    idle(2);
    check("err_full_pushpop", {29'd0, err_sticky}, 32'h0);

    // sop inside an open packet, then a clean packet
    dval_in = 1'b1; sop_in = 1'b1; din = 32'hFFFFFFFF;
    tick();
    dval_in = 1'b0; sop_in = 1'b0;
    load_pkt(4, 8'h10, 32'hF00DCAFE);
    send_pkt(8, 1'b0, 32'h0, 1'b0, 0);
    idle(2);
    issue_crc(32'hF00DCAFE, 1'b1, 1'b1, 8);
    idle(2);
    check("err_framing", {29'd0, err_sticky}, 32'h1);

    // Reset with a queued entry and an open packet: nothing survives
    single(32'h77777777);
    dval_in = 1'b1; sop_in = 1'b1; din = 32'h12345678;
    tick();
    dval_in = 1'b0; sop_in = 1'b0;
    apply_reset();
    issue_crc(32'h77777777, 1'b0, 1'b0, 0);
    idle(3);
    check("err_after_rst", {29'd0, err_sticky}, 32'h4);

    // Statistics: 3 good + 2 bad
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      single(32'h3C000000 + 32'(i));
      idle(2);
      issue_crc(i < 3 ? 32'h3C000000 + 32'(i) : 32'h00000000, 1'b1, i < 3, 4);
    end
    idle(3);
`ifdef CRC_CHK_STATS_EN
    check("good_cnt", good_cnt, 32'd3);
    check("bad_cnt", bad_cnt, 32'd2);
`else
    check("good_cnt", good_cnt, 32'd0);
    check("bad_cnt", bad_cnt, 32'd0);
`endif
    check("final_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
